// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the multiply sequencer.
//   mulState_t : sequencer state encoding (IDLE / ITER / WRITE, 2 bits)
//   FLAG_*     : bit positions inside the NZCV flag vector (same layout as execute)
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    WRITE = 2'd2
  } mulState_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add step of the multiply sequencer (purely combinational).
// Ports:
//   acc, mcand, mult       current accumulator, shifted multiplicand, remaining multiplier
//   acc_n, mcand_n, mult_n values after this step
//   last                   early-exit indication: no multiplier bits remain after this step
module mul_step #(
  parameter int DATA_W     = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mult,
  output logic [DATA_W-1:0] acc_n,
  output logic [DATA_W-1:0] mcand_n,
  output logic [DATA_W-1:0] mult_n,
  output logic              last
);

  // Sum wraps modulo 2^DATA_W; only the low product bits are ever needed.
  assign acc_n   = mult[0] ? (acc + mcand) : acc;
  assign mcand_n = mcand << 1;
  assign mult_n  = mult >> 1;
  assign last    = (EARLY_EXIT != 0) && (mult_n == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add sequencer for MUL/MULS. Stalls the front end while it
// iterates, then requests a single register-file write (plus N/Z for MULS).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    request pulse, accepted only when idle
//   setFlags, destReg        MULS select and destination, sampled on accept
//   opA, opB                 multiplicand, multiplier
//   flags_in                 current NZCV; C and V are carried through for MULS
//   wrAck                    register-file write port granted
//   stall, busy              front-end hold / sequencer active
//   writeToReg, writeReg,
//   writeData                write request, held until wrAck
//   flagsWrite, flags_out    flag update request and {N,Z,C,V}
//   done                     one-cycle pulse after the write is acknowledged
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// ITER  | one shift-add step per cycle
// WRITE | write request held until wrAck
module mul_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              setFlags,
  input  logic [REG_W-1:0]  destReg,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic [3:0]        flags_in,
  input  logic              wrAck,
  output logic              stall,
  output logic              busy,
  output logic              writeToReg,
  output logic [REG_W-1:0]  writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              flagsWrite,
  output logic [3:0]        flags_out,
  output logic              done
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  mulState_t         state;
  logic [DATA_W-1:0] acc, mcand, mult;
  logic [CNT_W-1:0]  count;
  logic              setFlagsQ;
  logic [3:0]        flagsQ;
  logic [DATA_W-1:0] accN, mcandN, multN;
  logic              stepLast, finalStep;
  logic [3:0]        flagsNext;

  mul_step #(
    .DATA_W     (DATA_W),
    .EARLY_EXIT (EARLY_EXIT)
  ) uStep (
    .acc     (acc),
    .mcand   (mcand),
    .mult    (mult),
    .acc_n   (accN),
    .mcand_n (mcandN),
    .mult_n  (multN),
    .last    (stepLast)
  );

  assign finalStep = stepLast || (count == LAST_CNT);

  // N and Z come from the final product; C and V are the accept-cycle sample.
  always_comb begin
    flagsNext         = flagsQ;
    flagsNext[FLAG_N] = accN[DATA_W-1];
    flagsNext[FLAG_Z] = (accN == '0);
  end

  assign stall      = start | busy;
  assign flagsWrite = writeToReg & setFlagsQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      mult       <= '0;
      count      <= '0;
      setFlagsQ  <= 1'b0;
      flagsQ     <= '0;
      busy       <= 1'b0;
      writeToReg <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
      flags_out  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            mcand     <= opA;
            mult      <= opB;
            count     <= '0;
            setFlagsQ <= setFlags;
            flagsQ    <= flags_in;
            writeReg  <= destReg;
            busy      <= 1'b1;
            state     <= ITER;
          end
        end
        ITER: begin
          acc   <= accN;
          mcand <= mcandN;
          mult  <= multN;
          if (finalStep) begin
            // count is left at its last value so it can never wrap.
            writeToReg <= 1'b1;
            writeData  <= accN;
            flags_out  <= flagsNext;
            state      <= WRITE;
          end else begin
            count <= count + 1'b1;
          end
        end
        WRITE: begin
          if (wrAck) begin
            writeToReg <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: the driver pushes expected results computed
// with plain arithmetic; a negedge monitor pops and compares on each write request.
module tb_mul_sequencer;
  import cpu_pkg::*;

  localparam int W  = 32;
  localparam int RW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, setFlags, wrAck;
  logic [RW-1:0] destReg;
  logic [W-1:0]  opA, opB;
  logic [3:0]    flagsIn;
  logic          stall, busy, writeToReg, flagsWrite, done;
  logic [RW-1:0] writeReg;
  logic [W-1:0]  writeData;
  logic [3:0]    flagsOut;

  logic          start0, wrAck0;
  logic [W-1:0]  opA0, opB0;
  logic          stall0, busy0, writeToReg0, flagsWrite0, done0;
  logic [RW-1:0] writeReg0;
  logic [W-1:0]  writeData0;
  logic [3:0]    flagsOut0;

  mul_sequencer #(.DATA_W(W), .REG_W(RW), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .setFlags(setFlags), .destReg(destReg),
    .opA(opA), .opB(opB), .flags_in(flagsIn), .wrAck(wrAck),
    .stall(stall), .busy(busy), .writeToReg(writeToReg), .writeReg(writeReg),
    .writeData(writeData), .flagsWrite(flagsWrite), .flags_out(flagsOut), .done(done)
  );

  mul_sequencer #(.DATA_W(W), .REG_W(RW), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .setFlags(1'b0), .destReg(4'd2),
    .opA(opA0), .opB(opB0), .flags_in(4'b0000), .wrAck(wrAck0),
    .stall(stall0), .busy(busy0), .writeToReg(writeToReg0), .writeReg(writeReg0),
    .writeData(writeData0), .flagsWrite(flagsWrite0), .flags_out(flagsOut0), .done(done0)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic [RW-1:0] dst;
    logic          fw;
    logic [3:0]    fl;
    int            iters;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nFails = 0;
  int   cyc = 0;
  int   nIssued = 0;
  int   nHandshakes = 0;
  bit   ackLow = 0;
  bit   junkEn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Iterations from the multiplier's highest set bit.
  function automatic int refIters(input logic [W-1:0] b, input bit early);
    if (!early) return W;
    for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  // ---------------- monitor ----------------
  bit            prevWr = 0, prevAck = 0, expectDone = 0;
  logic [W-1:0]  prevData;
  logic [RW-1:0] prevReg;

  always @(negedge clk) begin
    if (rst) begin
      prevWr = 0; prevAck = 0; expectDone = 0;
    end else begin
      exp_t e;
      check("done", 64'(done), 64'(expectDone));
      if (writeToReg && !prevWr) begin
        if (q.size() == 0) begin
          check("spuriousWrite_queueSize", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          check("writeData", 64'(writeData), 64'(e.data));
          check("writeReg", 64'(writeReg), 64'(e.dst));
          check("flagsWrite", 64'(flagsWrite), 64'(e.fw));
          if (e.fw) check("flags_out", 64'(flagsOut), 64'(e.fl));
          check("iterCycles", 64'(cyc - e.acc), 64'(e.iters));
        end
      end
      if (prevWr && !prevAck) begin
        check("wrHeld", 64'(writeToReg), 64'd1);
        check("dataStable", 64'(writeData), 64'(prevData));
        check("regStable", 64'(writeReg), 64'(prevReg));
      end
      if (writeToReg) begin
        check("stallInWrite", 64'(stall), 64'd1);
        check("busyInWrite", 64'(busy), 64'd1);
      end
      expectDone = writeToReg && wrAck;
      if (writeToReg && wrAck) nHandshakes++;
      prevWr = writeToReg; prevAck = wrAck;
      prevData = writeData; prevReg = writeReg;
    end
  end

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk); #2;
    wrAck = ackLow ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (junkEn && (nIssued != nHandshakes) && ($urandom_range(0, 1) == 1)) begin
      start = 1'b1; opA = $urandom; opB = $urandom; setFlags = 1'($urandom);
      destReg = 4'($urandom); flagsIn = 4'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sf,
                       input logic [RW-1:0] d, input logic [3:0] fl);
    exp_t e;
    logic [63:0] p;
    int t;
    t = 0;
    while (nIssued != nHandshakes && t < 400) begin cycle(); t++; end
    if (t >= 400) begin
      nChecks++; nFails++;
      $display("FAIL waitIdle: no write handshake within 400 cycles, got pending %0d expected 0", nIssued - nHandshakes);
      q.delete(); nIssued = nHandshakes;
    end
    start = 1'b1; opA = a; opB = b; setFlags = sf; destReg = d; flagsIn = fl;
    p = 64'(a) * 64'(b);
    e.data  = p[W-1:0];
    e.dst   = d;
    e.fw    = sf;
    e.fl    = {e.data[W-1], (e.data == '0), fl[1], fl[0]};
    e.iters = refIters(b, 1'b1);
    e.acc   = cyc + 1;
    q.push_back(e);
    nIssued++;
    cycle();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (nIssued != nHandshakes && t < 400) begin cycle(); t++; end
    check("drained", 64'(nIssued - nHandshakes), 64'd0);
  endtask

  task automatic runFull(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] expData);
    int n;
    @(posedge clk); #2;
    start0 = 1'b1; opA0 = a; opB0 = b;
    @(posedge clk); #2;
    start0 = 1'b0;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n = i;
      if (writeToReg0) break;
    end
    check("noEarly_writeSeen", 64'(writeToReg0), 64'd1);
    check("noEarly_iters", 64'(n - 1), 64'd32);
    check("noEarly_data", 64'(writeData0), 64'(expData));
    check("noEarly_reg", 64'(writeReg0), 64'd2);
    check("noEarly_flagsWrite", 64'(flagsWrite0), 64'd0);
    check("noEarly_busy", 64'(busy0 & stall0), 64'd1);
    @(negedge clk);
    check("noEarly_done", 64'(done0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; setFlags = 0; destReg = 0; opA = 0; opB = 0; flagsIn = 0; wrAck = 0;
    start0 = 0; wrAck0 = 1'b1; opA0 = 0; opB0 = 0;
    #3;
    check("reset_stallFollowsStart1", 64'(stall), 64'd1);
    start = 1'b0;
    #1;
    check("reset_stallFollowsStart0", 64'(stall), 64'd0);
    check("reset_outputs", {writeToReg, busy, done, flagsWrite, flagsOut, writeReg}, 64'd0);
    check("reset_data", 64'(writeData), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed cases
    issue(32'd3, 32'd5, 1'b0, 4'd4, 4'b0000);
    issue(32'hFFFF_FFFE, 32'd3, 1'b1, 4'd1, 4'b0011);
    issue(32'h0000_1234, 32'd0, 1'b1, 4'd7, 4'b0000);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd9, 4'b0110);

    // wrAck held low while extra starts arrive
    drain();
    issue(32'd3, 32'd5, 1'b0, 4'd5, 4'b0000);
    ackLow = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      start = 1'b1; opA = $urandom; opB = $urandom; destReg = 4'($urandom); setFlags = 1'($urandom);
    end
    ackLow = 0;
    drain();

    // Randomized traffic with junk starts while busy
    junkEn = 1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] b;
      b = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      issue($urandom, b, 1'($urandom), 4'($urandom), 4'($urandom));
    end
    drain();
    junkEn = 0;

    // Reset in the middle of ITER
    issue(32'h0000_1234, 32'h8000_0001, 1'b1, 4'd3, 4'b0000);
    repeat (3) cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midReset_outputs", {writeToReg, busy, done, flagsWrite, flagsOut, writeReg, stall}, 64'd0);
    check("midReset_data", 64'(writeData), 64'd0);
    q.delete();
    nIssued = nHandshakes;
    cycle();
    rst = 1'b0;
    repeat (40) cycle();
    issue(32'd7, 32'd6, 1'b0, 4'd6, 4'b0000);
    drain();

    // Fixed-length iteration instance
    runFull(32'd3, 32'd5, 32'd15);
    runFull(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
